// File: rtl/mul_arb_pkg.sv
// mul_arb_pkg: shared types for the multiplier-sharing arbiter
package mul_arb_pkg;
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
endpackage

// File: rtl/mul_share_arbiter_rr_arbiter.sv
// rr_arbiter: combinational round-robin pick starting at ptr and wrapping modulo NREQ
module rr_arbiter #(
    parameter  int NREQ = 2,
    localparam int IDW  = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  ptr,
    output logic [NREQ-1:0] gnt,
    output logic [IDW-1:0]  idx,
    output logic            any_valid
);
    logic [NREQ-1:0] rot;
    logic [IDW-1:0]  off;
    logic [IDW:0]    sum;

    // rotate so the pointer sits at bit 0, take the lowest set bit, then undo the rotation
    always_comb begin
        rot       = NREQ'({req, req} >> ptr);
        off       = '0;
        for (int k = NREQ - 1; k >= 0; k--)
            if (rot[k]) off = IDW'(k);
        sum       = {1'b0, ptr} + {1'b0, off};
        idx       = (sum >= (IDW+1)'(NREQ)) ? IDW'(sum - (IDW+1)'(NREQ)) : IDW'(sum);
        any_valid = |req;
        gnt       = any_valid ? NREQ'(1) << idx : '0;
    end
endmodule

// File: rtl/mul_share_arbiter.sv
// mul_share_arbiter: shares one val/rdy multiplier among NREQ requesters, one multiply in flight
module mul_share_arbiter
    import mul_arb_pkg::*;
#(
    parameter  int NREQ = 2,
    parameter  int W    = 6,
    localparam int IDW  = $clog2(NREQ)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NREQ-1:0]   req_recv_val,
    output logic [NREQ-1:0]   req_recv_rdy,
    input  logic [NREQ*W-1:0] req_a,
    input  logic [NREQ*W-1:0] req_b,
    output logic [NREQ-1:0]   req_send_val,
    input  logic [NREQ-1:0]   req_send_rdy,
    output logic [NREQ*W-1:0] req_c,
    output logic              mul_recv_val,
    input  logic              mul_recv_rdy,
    output logic [W-1:0]      mul_a,
    output logic [W-1:0]      mul_b,
    input  logic              mul_send_val,
    output logic              mul_send_rdy,
    input  logic [W-1:0]      mul_c,
    output logic              busy,
    output logic [IDW-1:0]    grant_id
);
    state_t          state, state_n;
    logic [IDW-1:0]  ptr, owner, win;
    logic [NREQ-1:0] gnt;
    logic            any_valid, fire;
    logic [W-1:0]    a_q, b_q, c_q;

    rr_arbiter #(.NREQ(NREQ)) u_rr (
        .req       (req_recv_val),
        .ptr       (ptr),
        .gnt       (gnt),
        .idx       (win),
        .any_valid (any_valid)
    );

    assign fire     = (state == IDLE) && any_valid;
    assign mul_a    = a_q;
    assign mul_b    = b_q;
    assign busy     = state != IDLE;
    assign grant_id = owner;

    // next state and per-state handshake outputs; only the owner lane ever sees a response
    always_comb begin
        state_n      = state;
        req_recv_rdy = '0;
        req_send_val = '0;
        req_c        = '0;
        mul_recv_val = 1'b0;
        mul_send_rdy = 1'b0;
        case (state)
            IDLE: begin
                req_recv_rdy = gnt;
                if (any_valid) state_n = ISSUE;
            end
            ISSUE: begin
                mul_recv_val = 1'b1;
                if (mul_recv_rdy) state_n = WAIT;
            end
            WAIT: begin
                mul_send_rdy = 1'b1;
                if (mul_send_val) state_n = RESP;
            end
            RESP: begin
                req_send_val[owner]  = 1'b1;
                req_c[owner*W +: W]  = c_q;
                if (req_send_rdy[owner]) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    // state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_n;
    end

    // grant bookkeeping, operand latch on request fire, result latch on multiplier fire
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr   <= '0;
            owner <= '0;
            a_q   <= '0;
            b_q   <= '0;
            c_q   <= '0;
        end else begin
            if (fire) begin
                owner <= win;
                ptr   <= (win == IDW'(NREQ - 1)) ? '0 : win + 1'b1;
                a_q   <= req_a[win*W +: W];
                b_q   <= req_b[win*W +: W];
            end
            if (state == WAIT && mul_send_val) c_q <= mul_c;
        end
    end
endmodule

// File: tb/tb_mul_share_arbiter.sv
// tb_mul_share_arbiter: scoreboard bench with a behavioural multiplier and round-robin reference model
module tb_mul_share_arbiter;
    localparam int NREQ = 2;
    localparam int W    = 6;
    localparam int IDW  = $clog2(NREQ);

    logic              clk = 1'b0, rst_n = 1'b0;
    logic [NREQ-1:0]   req_recv_val = '0, req_send_rdy = '1;
    logic [NREQ-1:0]   req_recv_rdy, req_send_val;
    logic [NREQ*W-1:0] req_a = '0, req_b = '0, req_c;
    logic              mul_recv_val, mul_send_rdy, busy;
    logic              mul_recv_rdy = 1'b0, mul_send_val = 1'b0;
    logic [W-1:0]      mul_a, mul_b, mul_c = '0;
    logic [IDW-1:0]    grant_id;

    typedef struct {
        int           lane;
        logic [W-1:0] c;
    } exp_t;

    exp_t              sb[$];
    exp_t              e;
    int                n_chk = 0, n_pass = 0;
    int                m_ptr = 0, m_owner = 0, w;
    bit                m_busy = 0, p_iss = 0;
    logic [W-1:0]      p_a, p_b;
    logic [NREQ*W-1:0] ec;
    bit                x_busy = 0, stall = 0;
    int                x_lat = 0, fix_lat = -1;
    logic [W-1:0]      x_prod;

    mul_share_arbiter #(.NREQ(NREQ), .W(W)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_recv_val (req_recv_val),
        .req_recv_rdy (req_recv_rdy),
        .req_a        (req_a),
        .req_b        (req_b),
        .req_send_val (req_send_val),
        .req_send_rdy (req_send_rdy),
        .req_c        (req_c),
        .mul_recv_val (mul_recv_val),
        .mul_recv_rdy (mul_recv_rdy),
        .mul_a        (mul_a),
        .mul_b        (mul_b),
        .mul_send_val (mul_send_val),
        .mul_send_rdy (mul_send_rdy),
        .mul_c        (mul_c),
        .busy         (busy),
        .grant_id     (grant_id)
    );

    always #5 clk = ~clk;

    function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    endfunction

    // multiplier handshakes observed mid-cycle; reset clears any in-flight product
    always @(negedge clk) begin
        if (!rst_n) x_busy = 0;
        else if (x_busy) begin
            if (x_lat == 0 && mul_send_val && mul_send_rdy) x_busy = 0;
        end else if (mul_recv_val && mul_recv_rdy) begin
            x_busy = 1;
            x_prod = mul_a * mul_b;
            x_lat  = fix_lat >= 0 ? fix_lat : int'($urandom_range(0, 3));
        end
    end

    // multiplier drive: random accept, random latency, junk valid pulses while idle
    always @(posedge clk) begin
        #1;
        if (x_busy && x_lat > 0) x_lat--;
        mul_recv_rdy = rst_n && !x_busy && !stall && ($urandom_range(0, 3) != 0);
        if (x_busy && x_lat == 0) begin
            mul_send_val = 1'b1;
            mul_c        = x_prod;
        end else begin
            mul_send_val = rst_n && !x_busy && ($urandom_range(0, 3) == 0);
            mul_c        = W'($urandom);
        end
    end

    // reference model and scoreboard: expected grant on request fire, compare on response
    always @(negedge clk) begin
        if (!rst_n) begin
            sb.delete();
            m_ptr = 0; m_owner = 0; m_busy = 0; p_iss = 0;
        end else begin
            chk("busy", 64'(busy), 64'(m_busy));
            chk("grant_id", 64'(grant_id), 64'(m_owner));
            if (p_iss) begin
                chk("stall_val", 64'(mul_recv_val), 64'(1));
                chk("stall_a", 64'(mul_a), 64'(p_a));
                chk("stall_b", 64'(mul_b), 64'(p_b));
            end
            p_iss = mul_recv_val && !mul_recv_rdy;
            p_a = mul_a; p_b = mul_b;
            if (m_busy) chk("recv_rdy_busy", 64'(req_recv_rdy), 64'(0));
            else begin
                w = -1;
                for (int k = 0; k < NREQ; k++)
                    if (w < 0 && req_recv_val[(m_ptr + k) % NREQ]) w = (m_ptr + k) % NREQ;
                chk("recv_rdy", 64'(req_recv_rdy), w < 0 ? 64'(0) : 64'(1) << w);
                if (w >= 0) begin
                    e.lane = w;
                    e.c    = W'((int'(req_a[w*W +: W]) * int'(req_b[w*W +: W])) % (1 << W));
                    sb.push_back(e);
                    m_ptr = (w + 1) % NREQ; m_owner = w; m_busy = 1;
                end
            end
            if (req_send_val != '0) begin
                if (sb.size() == 0) chk("spurious_rsp", 64'(req_send_val), 64'(0));
                else begin
                    e = sb[0];
                    ec = '0;
                    ec[e.lane*W +: W] = e.c;
                    chk("send_val", 64'(req_send_val), 64'(1) << e.lane);
                    chk("req_c", 64'(req_c), 64'(ec));
                    if (req_send_rdy[e.lane]) begin
                        void'(sb.pop_front());
                        m_busy = 0;
                    end
                end
            end
        end
    end

    task automatic chk_rst();
        chk("rst_recv_rdy", 64'(req_recv_rdy), 64'(0));
        chk("rst_send_val", 64'(req_send_val), 64'(0));
        chk("rst_req_c", 64'(req_c), 64'(0));
        chk("rst_mul_recv_val", 64'(mul_recv_val), 64'(0));
        chk("rst_mul_send_rdy", 64'(mul_send_rdy), 64'(0));
        chk("rst_mul_a", 64'(mul_a), 64'(0));
        chk("rst_mul_b", 64'(mul_b), 64'(0));
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_grant_id", 64'(grant_id), 64'(0));
    endtask

    task automatic wait_fire(input int l);
        int n = 0;
        do begin @(negedge clk); n++; end while (!req_recv_rdy[l] && n < 100);
        chk("fire_timeout", 64'(req_recv_rdy[l]), 64'(1));
        @(posedge clk); #1;
        req_recv_val = '0;
    endtask

    task automatic issue(input int l, input int a, input int b);
        @(posedge clk); #1;
        req_recv_val = '0;
        req_recv_val[l] = 1'b1;
        req_a[l*W +: W] = W'(a);
        req_b[l*W +: W] = W'(b);
        wait_fire(l);
    endtask

    task automatic wait_idle();
        int n = 0;
        do begin @(negedge clk); n++; end while ((busy || sb.size() != 0) && n < 300);
        chk("idle_timeout", 64'(busy || sb.size() != 0), 64'(0));
    endtask

    initial begin
        int n;
        @(negedge clk);
        chk_rst();
        @(negedge clk); #2 rst_n = 1'b1;

        // contention from pointer 0: grants must alternate
        @(posedge clk); #1;
        req_a = {W'(6), W'(3)};
        req_b = {W'(2), W'(4)};
        req_recv_val = '1;
        for (int k = 0; k < 4; k++) begin
            n = 0;
            do begin @(negedge clk); n++; end while (req_recv_rdy == '0 && n < 100);
            chk("grant_order", 64'(req_recv_rdy), 64'(1) << (k % 2));
        end
        @(posedge clk); #1;
        req_recv_val = '0;
        wait_idle();

        issue(0, 5, 7);
        wait_idle();
        issue(1, 63, 63);
        wait_idle();

        // response backpressure on lane 0 while lane 1 is waiting
        req_send_rdy = 2'b10;
        issue(0, 2, 3);
        n = 0;
        do begin @(negedge clk); n++; end while (!req_send_val[0] && n < 100);
        @(posedge clk); #1;
        req_recv_val[1] = 1'b1;
        req_a[W +: W] = W'(10);
        req_b[W +: W] = W'(3);
        repeat (10) begin
            @(negedge clk);
            chk("bp_send_val", 64'(req_send_val), 64'(1));
            chk("bp_req_c", 64'(req_c), 64'(6));
            chk("bp_recv_rdy", 64'(req_recv_rdy), 64'(0));
            chk("bp_mul_recv_val", 64'(mul_recv_val), 64'(0));
        end
        @(posedge clk); #1;
        req_send_rdy = '1;
        wait_fire(1);
        wait_idle();

        // multiplier refuses operands for five cycles
        stall = 1;
        issue(0, 3, 5);
        repeat (5) begin
            @(negedge clk);
            chk("st_mul_recv_val", 64'(mul_recv_val), 64'(1));
            chk("st_mul_a", 64'(mul_a), 64'(3));
            chk("st_mul_b", 64'(mul_b), 64'(5));
        end
        stall = 0;
        wait_idle();

        repeat (400) begin
            @(posedge clk); #1;
            req_recv_val = NREQ'($urandom);
            req_a = (NREQ*W)'({$urandom, $urandom});
            req_b = (NREQ*W)'({$urandom, $urandom});
            req_send_rdy = NREQ'($urandom);
        end
        @(posedge clk); #1;
        req_recv_val = '0;
        req_send_rdy = '1;
        wait_idle();

        // async reset while the multiplier holds a result in flight
        fix_lat = 8;
        issue(0, 9, 9);
        n = 0;
        do begin @(negedge clk); n++; end while (!mul_send_rdy && n < 100);
        chk("reach_wait", 64'(mul_send_rdy), 64'(1));
        #2 rst_n = 1'b0;
        #1 chk_rst();
        @(negedge clk); #2 rst_n = 1'b1;
        fix_lat = -1;
        @(posedge clk); #1;
        req_a = {W'(4), W'(11)};
        req_b = {W'(4), W'(2)};
        req_recv_val = '1;
        @(negedge clk);
        chk("post_reset_grant", 64'(req_recv_rdy), 64'(1));
        @(posedge clk); #1;
        req_recv_val = '0;
        wait_idle();

        chk("sb_drained", 64'(sb.size()), 64'(0));
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
